// File: rtl/net_endpoint_requester_pkg.sv
// Shared definitions for the ring-network terminal endpoint: net message layout,
// default field widths, tag index type and the client response record.
package net_endpoint_requester_pkg;

  localparam int unsigned NET_PAYLOAD_NBITS = 8;
  localparam int unsigned NET_OPAQUE_NBITS  = 8;
  localparam int unsigned NET_SRCDEST_NBITS = 3;
  localparam int unsigned NET_NUM_TAGS      = 4;

  // Message layout, MSB to LSB: {dest, src, opaque, payload}
  function automatic int unsigned vc_net_msg_nbits(input int unsigned pl, input int unsigned op,
                                                   input int unsigned sd);
    return pl + op + 2 * sd;
  endfunction

  function automatic int unsigned vc_net_msg_opaque_lsb(input int unsigned pl);
    return pl;
  endfunction

  function automatic int unsigned vc_net_msg_src_lsb(input int unsigned pl, input int unsigned op);
    return pl + op;
  endfunction

  function automatic int unsigned vc_net_msg_dest_lsb(input int unsigned pl, input int unsigned op,
                                                      input int unsigned sd);
    return pl + op + sd;
  endfunction

  localparam int unsigned VC_NET_MSG_NBITS =
    vc_net_msg_nbits(NET_PAYLOAD_NBITS, NET_OPAQUE_NBITS, NET_SRCDEST_NBITS);

  typedef logic [$clog2(NET_NUM_TAGS)-1:0] tag_idx_t;

  typedef struct packed {
    logic [NET_SRCDEST_NBITS-1:0] src;
    logic [NET_OPAQUE_NBITS-1:0]  opaque;
    logic [NET_PAYLOAD_NBITS-1:0] payload;
  } resp_t;

endpackage

// File: rtl/net_endpoint_requester_if.sv
// Client request/response and router injection/ejection handshakes of the endpoint.
interface net_endpoint_requester_if
  import net_endpoint_requester_pkg::*;
#(
  parameter int unsigned p_payload_nbits = NET_PAYLOAD_NBITS,
  parameter int unsigned p_opaque_nbits  = NET_OPAQUE_NBITS,
  parameter int unsigned p_srcdest_nbits = NET_SRCDEST_NBITS
);
  localparam int unsigned c_msg_nbits =
    vc_net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);

  logic                       req_val;
  logic                       req_rdy;
  logic [p_srcdest_nbits-1:0] req_dest;
  logic [p_payload_nbits-1:0] req_payload;

  logic                       net_out_val;
  logic                       net_out_rdy;
  logic [c_msg_nbits-1:0]     net_out_msg;

  logic                       net_in_val;
  logic                       net_in_rdy;
  logic [c_msg_nbits-1:0]     net_in_msg;

  logic                       resp_val;
  logic                       resp_rdy;
  logic [p_srcdest_nbits-1:0] resp_src;
  logic [p_opaque_nbits-1:0]  resp_opaque;
  logic [p_payload_nbits-1:0] resp_payload;

  modport slave (
    input  req_val, req_dest, req_payload, net_out_rdy, net_in_val, net_in_msg, resp_rdy,
    output req_rdy, net_out_val, net_out_msg, net_in_rdy, resp_val, resp_src, resp_opaque,
           resp_payload
  );

  modport master (
    output req_val, req_dest, req_payload, net_out_rdy, net_in_val, net_in_msg, resp_rdy,
    input  req_rdy, net_out_val, net_out_msg, net_in_rdy, resp_val, resp_src, resp_opaque,
           resp_payload
  );

endinterface

// File: rtl/net_endpoint_tag_alloc.sv
// Outstanding-tag tracker: busy vector, lowest-free allocation, retire port, popcount.
module net_endpoint_tag_alloc #(
  parameter  int unsigned p_num_tags  = 4,
  localparam int unsigned c_idx_nbits = (p_num_tags > 1) ? $clog2(p_num_tags) : 1,
  localparam int unsigned c_cnt_nbits = $clog2(p_num_tags) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_alloc_en,
  output logic [c_idx_nbits-1:0] o_alloc_idx,
  output logic                   o_any_free,
  input  logic                   i_free_en,
  input  logic [c_idx_nbits-1:0] i_free_idx,
  output logic [p_num_tags-1:0]  o_busy,
  output logic [c_cnt_nbits-1:0] o_count
);

  logic [p_num_tags-1:0] r_busy;
  logic [p_num_tags-1:0] w_busy_next;

  // Scan downward so the last hit, i.e. the lowest free index, wins
  always_comb begin
    o_alloc_idx = '0;
    o_any_free  = 1'b0;
    for (int unsigned i = p_num_tags; i > 0; i--) begin
      if (!r_busy[i-1]) begin
        o_alloc_idx = c_idx_nbits'(i - 1);
        o_any_free  = 1'b1;
      end
    end
  end

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < p_num_tags; i++) begin
      o_count = o_count + c_cnt_nbits'(r_busy[i]);
    end
  end

  // Allocation index comes from the pre-update vector, so it never equals a tag retired this cycle
  always_comb begin
    w_busy_next = r_busy;
    if (i_free_en) begin
      w_busy_next[i_free_idx] = 1'b0;
    end
    if (i_alloc_en && o_any_free) begin
      w_busy_next[o_alloc_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/net_endpoint_requester.sv
// Terminal-side ring network endpoint: tags and injects client requests, retires
// tags on ejection, returns {src, opaque, payload} and flags bad arrivals.
module net_endpoint_requester
  import net_endpoint_requester_pkg::*;
#(
  parameter int unsigned p_payload_nbits = NET_PAYLOAD_NBITS,
  parameter int unsigned p_opaque_nbits  = NET_OPAQUE_NBITS,
  parameter int unsigned p_srcdest_nbits = NET_SRCDEST_NBITS,
  parameter int unsigned p_router_id     = 0,
  parameter int unsigned p_num_tags      = NET_NUM_TAGS
) (
  input  logic                          clk,
  input  logic                          reset,
  net_endpoint_requester_if.slave       bus,
  output logic [$clog2(p_num_tags):0]   outstanding,
  output logic                          err_misroute,
  output logic                          err_spurious
);

  localparam int unsigned c_msg_nbits =
    vc_net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);
  localparam int unsigned c_opq_lsb  = vc_net_msg_opaque_lsb(p_payload_nbits);
  localparam int unsigned c_src_lsb  = vc_net_msg_src_lsb(p_payload_nbits, p_opaque_nbits);
  localparam int unsigned c_dest_lsb =
    vc_net_msg_dest_lsb(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);
  localparam int unsigned c_idx_nbits = (p_num_tags > 1) ? $clog2(p_num_tags) : 1;
  localparam logic [p_srcdest_nbits-1:0] c_own_id = p_srcdest_nbits'(p_router_id);

  typedef struct packed {
    logic [p_srcdest_nbits-1:0] src;
    logic [p_opaque_nbits-1:0]  opaque;
    logic [p_payload_nbits-1:0] payload;
  } ep_resp_t;

  logic                   w_any_free;
  logic [c_idx_nbits-1:0] w_alloc_idx;
  logic [p_num_tags-1:0]  w_busy;
  logic                   w_free_en;
  logic                   w_req_fire;

  net_endpoint_tag_alloc #(.p_num_tags(p_num_tags)) u_tag_alloc (
    .clk         (clk),
    .reset       (reset),
    .i_alloc_en  (w_req_fire),
    .o_alloc_idx (w_alloc_idx),
    .o_any_free  (w_any_free),
    .i_free_en   (w_free_en),
    .i_free_idx  (bus.net_in_msg[c_opq_lsb +: c_idx_nbits]),
    .o_busy      (w_busy),
    .o_count     (outstanding)
  );

  // Two-entry injection queue, registered output, no bypass path
  logic [c_msg_nbits-1:0] r_q_data [2];
  logic                   r_q_head;
  logic [1:0]             r_q_cnt;
  logic                   w_q_full;
  logic                   w_q_tail;
  logic                   w_deq;
  logic [c_msg_nbits-1:0] w_new_msg;

  assign w_q_full        = (r_q_cnt == 2'd2);
  assign w_q_tail        = r_q_head ^ r_q_cnt[0];
  assign bus.req_rdy     = w_any_free && !w_q_full;
  assign w_req_fire      = bus.req_val && bus.req_rdy;
  assign bus.net_out_val = (r_q_cnt != 2'd0);
  assign bus.net_out_msg = r_q_data[r_q_head];
  assign w_deq           = bus.net_out_val && bus.net_out_rdy;
  assign w_new_msg       = {bus.req_dest, c_own_id, p_opaque_nbits'(w_alloc_idx), bus.req_payload};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_head    <= 1'b0;
      r_q_cnt     <= '0;
    end else begin
      if (w_req_fire) begin
        r_q_data[w_q_tail] <= w_new_msg;
      end
      if (w_deq) begin
        r_q_head <= ~r_q_head;
      end
      r_q_cnt <= r_q_cnt + 2'(w_req_fire) - 2'(w_deq);
    end
  end

  // Ejection: one-entry response register
  logic [p_srcdest_nbits-1:0] w_in_dest;
  logic [p_opaque_nbits-1:0]  w_in_opaque;
  logic                       w_in_fire;
  logic                       w_dest_ok;
  logic                       w_opq_in_range;
  logic                       w_hit;
  logic                       r_resp_val;
  ep_resp_t                   r_resp;

  assign w_in_dest      = bus.net_in_msg[c_dest_lsb +: p_srcdest_nbits];
  assign w_in_opaque    = bus.net_in_msg[c_opq_lsb +: p_opaque_nbits];
  assign bus.net_in_rdy = !r_resp_val || bus.resp_rdy;
  assign w_in_fire      = bus.net_in_val && bus.net_in_rdy;
  assign w_dest_ok      = (w_in_dest == c_own_id);
  assign w_opq_in_range = (33'(w_in_opaque) < 33'(p_num_tags));
  assign w_hit          = w_dest_ok && w_opq_in_range && w_busy[w_in_opaque[c_idx_nbits-1:0]];
  assign w_free_en      = w_in_fire && w_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_val   <= 1'b0;
      r_resp       <= '0;
      err_misroute <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (w_in_fire && w_dest_ok) begin
        r_resp_val <= 1'b1;
        r_resp     <= '{src:     bus.net_in_msg[c_src_lsb +: p_srcdest_nbits],
                        opaque:  w_in_opaque,
                        payload: bus.net_in_msg[p_payload_nbits-1:0]};
      end else if (bus.resp_rdy) begin
        r_resp_val <= 1'b0;
      end
      if (w_in_fire && !w_dest_ok) begin
        err_misroute <= 1'b1;
      end
      if (w_in_fire && w_dest_ok && !w_hit) begin
        err_spurious <= 1'b1;
      end
    end
  end

  assign bus.resp_val     = r_resp_val;
  assign bus.resp_src     = r_resp.src;
  assign bus.resp_opaque  = r_resp.opaque;
  assign bus.resp_payload = r_resp.payload;

endmodule

// File: tb/tb_net_endpoint_requester.sv
// Scenario bench for net_endpoint_requester (router id 2, 4 tags) with scoreboards.
module tb_net_endpoint_requester;
  import net_endpoint_requester_pkg::*;

  localparam logic [2:0] OWN = 3'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] outstanding;
  logic       err_misroute;
  logic       err_spurious;

  always #5 clk = ~clk;

  net_endpoint_requester_if #(.p_payload_nbits(8), .p_opaque_nbits(8), .p_srcdest_nbits(3)) bus ();

  net_endpoint_requester #(
    .p_payload_nbits (8),
    .p_opaque_nbits  (8),
    .p_srcdest_nbits (3),
    .p_router_id     (2),
    .p_num_tags      (4)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .bus          (bus.slave),
    .outstanding  (outstanding),
    .err_misroute (err_misroute),
    .err_spurious (err_spurious)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [21:0] exp_out_q [$];
  resp_t       exp_resp_q [$];

  function automatic logic [21:0] mk_msg(input logic [2:0] d, input logic [2:0] s,
                                         input logic [7:0] o, input logic [7:0] p);
    return {d, s, o, p};
  endfunction

  function automatic resp_t mk_resp(input logic [2:0] s, input logic [7:0] o, input logic [7:0] p);
    return '{src: s, opaque: o, payload: p};
  endfunction

  task automatic idle_inputs();
    bus.req_val     = 1'b0;
    bus.req_dest    = '0;
    bus.req_payload = '0;
    bus.net_out_rdy = 1'b1;
    bus.net_in_val  = 1'b0;
    bus.net_in_msg  = '0;
    bus.resp_rdy    = 1'b1;
  endtask

  task automatic drive_req(input logic [2:0] d, input logic [7:0] p);
    bus.req_val     = 1'b1;
    bus.req_dest    = d;
    bus.req_payload = p;
  endtask

  task automatic drive_net_in(input logic [21:0] m);
    bus.net_in_val = 1'b1;
    bus.net_in_msg = m;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.net_out_val, bus.resp_val, bus.net_in_rdy, bus.req_rdy, err_misroute, err_spurious}
        !== 6'b001100) begin
      n_errors++;
      $display("FAIL reset_flags: got %b need 001100", {bus.net_out_val, bus.resp_val,
               bus.net_in_rdy, bus.req_rdy, err_misroute, err_spurious});
    end
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_outstanding: got %0d need 0", outstanding);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [21:0] e;
    n_checks++;
    if (bus.req_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL single_req_rdy: got %b need 1", bus.req_rdy);
    end
    drive_req(3'd4, 8'hff);
    exp_out_q.push_back(mk_msg(3'd4, OWN, 8'h00, 8'hff));
    @(negedge clk);
    bus.req_val = 1'b0;
    e = exp_out_q.pop_front();
    n_checks++;
    if (bus.net_out_val !== 1'b1 || bus.net_out_msg !== e) begin
      n_errors++;
      $display("FAIL single_msg: val=%b msg=%h need val=1 msg=%h", bus.net_out_val, bus.net_out_msg, e);
    end
    n_checks++;
    if (outstanding !== 3'd1) begin
      n_errors++;
      $display("FAIL single_outstanding: got %0d need 1", outstanding);
    end
    @(negedge clk);
    n_checks++;
    if (bus.net_out_val !== 1'b0) begin
      n_errors++;
      $display("FAIL single_drained: net_out_val=%b need 0", bus.net_out_val);
    end
  endtask

  task automatic test_loopback();
    resp_t e;
    n_checks++;
    if (bus.net_in_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL loopback_in_rdy: got %b need 1", bus.net_in_rdy);
    end
    drive_net_in(mk_msg(OWN, 3'd4, 8'h00, 8'hab));
    exp_resp_q.push_back(mk_resp(3'd4, 8'h00, 8'hab));
    @(negedge clk);
    bus.net_in_val = 1'b0;
    e = exp_resp_q.pop_front();
    n_checks++;
    if (bus.resp_val !== 1'b1 || {bus.resp_src, bus.resp_opaque, bus.resp_payload} !== e) begin
      n_errors++;
      $display("FAIL loopback_resp: val=%b got %h need %h", bus.resp_val,
               {bus.resp_src, bus.resp_opaque, bus.resp_payload}, e);
    end
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_errors++;
      $display("FAIL loopback_outstanding: got %0d need 0", outstanding);
    end
    @(negedge clk);
    n_checks++;
    if (bus.resp_val !== 1'b0) begin
      n_errors++;
      $display("FAIL loopback_resp_clear: resp_val=%b need 0", bus.resp_val);
    end
  endtask

  task automatic test_exhaustion();
    logic [21:0] e;
    resp_t       r;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        e = exp_out_q.pop_front();
        n_checks++;
        if (bus.net_out_val !== 1'b1 || bus.net_out_msg !== e) begin
          n_errors++;
          $display("FAIL exhaust_msg%0d: val=%b msg=%h need %h", k - 1, bus.net_out_val,
                   bus.net_out_msg, e);
        end
      end
      drive_req(3'(k + 1), 8'(8'h10 + k));
      n_checks++;
      if (bus.req_rdy !== (k < 4)) begin
        n_errors++;
        $display("FAIL exhaust_req_rdy%0d: got %b need %b", k, bus.req_rdy, (k < 4));
      end
      if (k < 4) exp_out_q.push_back(mk_msg(3'(k + 1), OWN, 8'(k), 8'(8'h10 + k)));
      if (k < 4) @(negedge clk);
    end
    n_checks++;
    if (outstanding !== 3'd4) begin
      n_errors++;
      $display("FAIL exhaust_outstanding: got %0d need 4", outstanding);
    end
    @(negedge clk);
    bus.req_val = 1'b0;
    n_checks++;
    if (bus.net_out_val !== 1'b0) begin
      n_errors++;
      $display("FAIL exhaust_no_fifth: net_out_val=%b need 0", bus.net_out_val);
    end
    drive_net_in(mk_msg(OWN, 3'd5, 8'h01, 8'h11));
    exp_resp_q.push_back(mk_resp(3'd5, 8'h01, 8'h11));
    @(negedge clk);
    bus.net_in_val = 1'b0;
    r = exp_resp_q.pop_front();
    n_checks++;
    if (bus.resp_val !== 1'b1 || {bus.resp_src, bus.resp_opaque, bus.resp_payload} !== r) begin
      n_errors++;
      $display("FAIL exhaust_ret1_resp: val=%b got %h need %h", bus.resp_val,
               {bus.resp_src, bus.resp_opaque, bus.resp_payload}, r);
    end
    n_checks++;
    if (outstanding !== 3'd3 || bus.req_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL exhaust_ret1_state: outstanding=%0d req_rdy=%b need 3 1", outstanding, bus.req_rdy);
    end
    drive_req(3'd6, 8'h55);
    exp_out_q.push_back(mk_msg(3'd6, OWN, 8'h01, 8'h55));
    @(negedge clk);
    bus.req_val = 1'b0;
    e = exp_out_q.pop_front();
    n_checks++;
    if (bus.net_out_val !== 1'b1 || bus.net_out_msg !== e) begin
      n_errors++;
      $display("FAIL exhaust_reuse1: val=%b msg=%h need %h", bus.net_out_val, bus.net_out_msg, e);
    end
    drive_net_in(mk_msg(OWN, 3'd4, 8'h03, 8'h13));
    exp_resp_q.push_back(mk_resp(3'd4, 8'h03, 8'h13));
    @(negedge clk);
    bus.net_in_val = 1'b0;
    r = exp_resp_q.pop_front();
    n_checks++;
    if (bus.resp_val !== 1'b1 || {bus.resp_src, bus.resp_opaque, bus.resp_payload} !== r
        || outstanding !== 3'd3) begin
      n_errors++;
      $display("FAIL exhaust_ret3: val=%b got %h outstanding=%0d need %h 3", bus.resp_val,
               {bus.resp_src, bus.resp_opaque, bus.resp_payload}, outstanding, r);
    end
  endtask

  task automatic test_same_cycle_free();
    logic [21:0] e;
    resp_t       r;
    drive_req(3'd1, 8'h77);
    drive_net_in(mk_msg(OWN, 3'd7, 8'h00, 8'h99));
    exp_out_q.push_back(mk_msg(3'd1, OWN, 8'h03, 8'h77));
    exp_resp_q.push_back(mk_resp(3'd7, 8'h00, 8'h99));
    @(negedge clk);
    bus.req_val    = 1'b0;
    bus.net_in_val = 1'b0;
    n_checks++;
    if (outstanding !== 3'd3) begin
      n_errors++;
      $display("FAIL samecyc_outstanding: got %0d need 3", outstanding);
    end
    e = exp_out_q.pop_front();
    n_checks++;
    if (bus.net_out_val !== 1'b1 || bus.net_out_msg !== e) begin
      n_errors++;
      $display("FAIL samecyc_tag: val=%b msg=%h need %h", bus.net_out_val, bus.net_out_msg, e);
    end
    r = exp_resp_q.pop_front();
    n_checks++;
    if (bus.resp_val !== 1'b1 || {bus.resp_src, bus.resp_opaque, bus.resp_payload} !== r) begin
      n_errors++;
      $display("FAIL samecyc_resp: val=%b got %h need %h", bus.resp_val,
               {bus.resp_src, bus.resp_opaque, bus.resp_payload}, r);
    end
    drive_req(3'd3, 8'h42);
    exp_out_q.push_back(mk_msg(3'd3, OWN, 8'h00, 8'h42));
    @(negedge clk);
    bus.req_val = 1'b0;
    e = exp_out_q.pop_front();
    n_checks++;
    if (bus.net_out_val !== 1'b1 || bus.net_out_msg !== e || outstanding !== 3'd4) begin
      n_errors++;
      $display("FAIL samecyc_next_tag0: msg=%h outstanding=%0d need %h 4", bus.net_out_msg,
               outstanding, e);
    end
    for (int t = 0; t <= 4; t++) begin
      if (t > 0) begin
        r = exp_resp_q.pop_front();
        n_checks++;
        if (bus.resp_val !== 1'b1 || {bus.resp_src, bus.resp_opaque, bus.resp_payload} !== r) begin
          n_errors++;
          $display("FAIL retire_resp%0d: val=%b got %h need %h", t - 1, bus.resp_val,
                   {bus.resp_src, bus.resp_opaque, bus.resp_payload}, r);
        end
      end
      if (t < 4) begin
        drive_net_in(mk_msg(OWN, 3'd1, 8'(t), 8'(8'h20 + t)));
        exp_resp_q.push_back(mk_resp(3'd1, 8'(t), 8'(8'h20 + t)));
        @(negedge clk);
      end else begin
        bus.net_in_val = 1'b0;
      end
    end
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_errors++;
      $display("FAIL retire_all_outstanding: got %0d need 0", outstanding);
    end
  endtask

  task automatic test_backpressure();
    int unsigned idx = 0;
    int unsigned n_acc = 0;
    int unsigned n_drain = 0;
    int          first_drain = -1;
    int          last_drain = -1;
    resp_t       r;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.net_out_rdy = (cyc >= 5);
      if (bus.net_out_val) begin
        n_checks++;
        if (exp_out_q.size() == 0) begin
          n_errors++;
          $display("FAIL bp_unexpected_msg: cyc %0d msg=%h", cyc, bus.net_out_msg);
        end else begin
          if (bus.net_out_msg !== exp_out_q[0]) begin
            n_errors++;
            $display("FAIL bp_msg cyc%0d: got %h need %h", cyc, bus.net_out_msg, exp_out_q[0]);
          end
          if (bus.net_out_rdy) begin
            void'(exp_out_q.pop_front());
            n_drain++;
            if (first_drain < 0) first_drain = cyc;
            last_drain = cyc;
          end
        end
      end
      if (idx < 3) begin
        drive_req(3'(idx + 3), 8'(8'ha0 + idx));
        if (bus.req_rdy) begin
          exp_out_q.push_back(mk_msg(3'(idx + 3), OWN, 8'(idx), 8'(8'ha0 + idx)));
          idx++;
          n_acc++;
        end
      end else begin
        bus.req_val = 1'b0;
      end
      if (cyc == 4) begin
        n_checks++;
        if (n_acc != 2) begin
          n_errors++;
          $display("FAIL bp_accepted_while_stalled: got %0d need 2", n_acc);
        end
      end
      @(negedge clk);
    end
    bus.req_val = 1'b0;
    n_checks++;
    if (n_drain != 3 || last_drain - first_drain != 2 || exp_out_q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_drain: drained=%0d span=%0d left=%0d need 3 2 0", n_drain,
               last_drain - first_drain, exp_out_q.size());
    end
    n_checks++;
    if (outstanding !== 3'd3) begin
      n_errors++;
      $display("FAIL bp_outstanding: got %0d need 3", outstanding);
    end
    for (int t = 0; t <= 3; t++) begin
      if (t > 0) begin
        r = exp_resp_q.pop_front();
        n_checks++;
        if (bus.resp_val !== 1'b1 || {bus.resp_src, bus.resp_opaque, bus.resp_payload} !== r) begin
          n_errors++;
          $display("FAIL bp_retire%0d: val=%b got %h need %h", t - 1, bus.resp_val,
                   {bus.resp_src, bus.resp_opaque, bus.resp_payload}, r);
        end
      end
      if (t < 3) begin
        drive_net_in(mk_msg(OWN, 3'(t + 3), 8'(t), 8'(8'hc0 + t)));
        exp_resp_q.push_back(mk_resp(3'(t + 3), 8'(t), 8'(8'hc0 + t)));
        @(negedge clk);
      end else begin
        bus.net_in_val = 1'b0;
      end
    end
  endtask

  task automatic test_self_send();
    logic [21:0] e;
    resp_t       r;
    drive_req(OWN, 8'h5a);
    exp_out_q.push_back(mk_msg(OWN, OWN, 8'h00, 8'h5a));
    @(negedge clk);
    bus.req_val = 1'b0;
    e = exp_out_q.pop_front();
    n_checks++;
    if (bus.net_out_val !== 1'b1 || bus.net_out_msg !== e) begin
      n_errors++;
      $display("FAIL self_msg: val=%b msg=%h need %h", bus.net_out_val, bus.net_out_msg, e);
    end
    drive_net_in(mk_msg(OWN, OWN, 8'h00, 8'h5a));
    exp_resp_q.push_back(mk_resp(OWN, 8'h00, 8'h5a));
    @(negedge clk);
    bus.net_in_val = 1'b0;
    r = exp_resp_q.pop_front();
    n_checks++;
    if (bus.resp_val !== 1'b1 || {bus.resp_src, bus.resp_opaque, bus.resp_payload} !== r
        || outstanding !== 3'd0) begin
      n_errors++;
      $display("FAIL self_resp: val=%b got %h outstanding=%0d need %h 0", bus.resp_val,
               {bus.resp_src, bus.resp_opaque, bus.resp_payload}, outstanding, r);
    end
    n_checks++;
    if ({err_misroute, err_spurious} !== 2'b00) begin
      n_errors++;
      $display("FAIL self_no_errors: flags=%b need 00", {err_misroute, err_spurious});
    end
  endtask

  task automatic test_errors();
    resp_t r;
    drive_net_in(mk_msg(3'd5, 3'd3, 8'h00, 8'h33));
    @(negedge clk);
    bus.net_in_val = 1'b0;
    n_checks++;
    if (bus.resp_val !== 1'b0 || err_misroute !== 1'b1 || err_spurious !== 1'b0
        || outstanding !== 3'd0) begin
      n_errors++;
      $display("FAIL misroute: resp_val=%b mis=%b spur=%b outstanding=%0d need 0 1 0 0",
               bus.resp_val, err_misroute, err_spurious, outstanding);
    end
    drive_net_in(mk_msg(OWN, 3'd6, 8'h02, 8'h66));
    exp_resp_q.push_back(mk_resp(3'd6, 8'h02, 8'h66));
    @(negedge clk);
    r = exp_resp_q.pop_front();
    n_checks++;
    if (bus.resp_val !== 1'b1 || {bus.resp_src, bus.resp_opaque, bus.resp_payload} !== r
        || err_spurious !== 1'b1 || outstanding !== 3'd0) begin
      n_errors++;
      $display("FAIL spurious_free_tag: val=%b got %h spur=%b outstanding=%0d need %h 1 0",
               bus.resp_val, {bus.resp_src, bus.resp_opaque, bus.resp_payload}, err_spurious,
               outstanding, r);
    end
    drive_net_in(mk_msg(OWN, 3'd1, 8'h09, 8'h99));
    exp_resp_q.push_back(mk_resp(3'd1, 8'h09, 8'h99));
    @(negedge clk);
    bus.net_in_val = 1'b0;
    r = exp_resp_q.pop_front();
    n_checks++;
    if (bus.resp_val !== 1'b1 || {bus.resp_src, bus.resp_opaque, bus.resp_payload} !== r
        || outstanding !== 3'd0) begin
      n_errors++;
      $display("FAIL spurious_range: val=%b got %h outstanding=%0d need %h 0", bus.resp_val,
               {bus.resp_src, bus.resp_opaque, bus.resp_payload}, outstanding, r);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({err_misroute, err_spurious} !== 2'b11) begin
      n_errors++;
      $display("FAIL errors_sticky: flags=%b need 11", {err_misroute, err_spurious});
    end
  endtask

  task automatic test_reset_mid();
    bus.net_out_rdy = 1'b0;
    bus.resp_rdy    = 1'b0;
    drive_req(3'd4, 8'h01);
    @(negedge clk);
    drive_req(3'd5, 8'h02);
    drive_net_in(mk_msg(OWN, 3'd1, 8'h07, 8'h01));
    @(negedge clk);
    bus.req_val    = 1'b0;
    bus.net_in_val = 1'b0;
    n_checks++;
    if (bus.net_out_val !== 1'b1 || bus.resp_val !== 1'b1 || outstanding !== 3'd2) begin
      n_errors++;
      $display("FAIL midrst_busy: out_val=%b resp_val=%b outstanding=%0d need 1 1 2",
               bus.net_out_val, bus.resp_val, outstanding);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.net_out_val, bus.resp_val, bus.net_in_rdy, bus.req_rdy, err_misroute, err_spurious}
        !== 6'b001100 || outstanding !== 3'd0) begin
      n_errors++;
      $display("FAIL midrst_async: flags=%b outstanding=%0d need 001100 0", {bus.net_out_val,
               bus.resp_val, bus.net_in_rdy, bus.req_rdy, err_misroute, err_spurious}, outstanding);
    end
    exp_out_q.delete();
    exp_resp_q.delete();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.net_out_val !== 1'b0 || bus.resp_val !== 1'b0 || outstanding !== 3'd0) begin
        n_errors++;
        $display("FAIL midrst_quiet%0d: out_val=%b resp_val=%b outstanding=%0d need 0 0 0", c,
                 bus.net_out_val, bus.resp_val, outstanding);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_loopback();
    test_exhaustion();
    test_same_cycle_free();
    test_backpressure();
    test_self_send();
    test_errors();
    test_reset_mid();
    n_checks++;
    if (exp_out_q.size() != 0 || exp_resp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: out=%0d resp=%0d need 0 0", exp_out_q.size(),
               exp_resp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/net_endpoint_requester.md
Name: net_endpoint_requester

Overview:
- Terminal-side endpoint for the ring network: the client end of the router's terminal port.
- Injection: takes client requests (dest, payload), allocates an opaque tag, stamps src = own id, and issues standard net messages into the router's terminal input.
- Ejection: accepts net messages from the router's terminal output, retires the matching tag, and hands {src, opaque, payload} to the client.
- Bounds outstanding traffic to p_num_tags and flags misrouted or spurious arrivals.

Parameters:
- p_payload_nbits, 8, payload field width
- p_opaque_nbits, 8, opaque field width; tag carried here
- p_srcdest_nbits, 3, src/dest field width
- p_router_id, 0, this terminal's id; stamped as src, compared to dest
- p_num_tags, 4, max outstanding requests; must be power of 2 and <= 2^p_opaque_nbits

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_val  in  1  client request valid
- req_rdy  out  1  request accepted when val && rdy
- req_dest  in  p_srcdest_nbits  destination terminal
- req_payload  in  p_payload_nbits  payload
- net_out_val  out  1  injection valid, to router terminal input
- net_out_rdy  in  1  router ready
- net_out_msg  out  VC_NET_MSG_NBITS  net message {dest, src, opaque, payload}, fields per VC_NET_MSG_*_FIELD
- net_in_val  in  1  ejection valid, from router terminal output
- net_in_rdy  out  1  ejection ready
- net_in_msg  in  VC_NET_MSG_NBITS  net message
- resp_val  out  1  response to client valid
- resp_rdy  in  1  client ready
- resp_src  out  p_srcdest_nbits  src field of arrived message
- resp_opaque  out  p_opaque_nbits  tag of arrived message
- resp_payload  out  p_payload_nbits  payload
- outstanding  out  clog2(p_num_tags)+1  count of busy tags
- err_misroute  out  1  sticky: a message with dest != p_router_id arrived
- err_spurious  out  1  sticky: arrival with tag free or opaque >= p_num_tags

Behaviour:
- Reset (reset low, async): all tags free; injection queue and response register empty; net_out_val = 0, resp_val = 0, net_in_rdy = 1, req_rdy = 1, outstanding = 0, both err flags = 0. Reset mid-operation discards all in-flight state; no message is emitted after reset deasserts until a new req fires.
- Tag allocator: busy bit-vector of p_num_tags bits.
  - req_rdy = (any tag free) && (injection queue not full).
  - On req fire, set busy[t] for the lowest free index t; opaque = t zero-extended.
  - Allocation uses the pre-update vector, so a tag freed in the same cycle is not reused until the next cycle.
- Injection queue: 2-entry FIFO, registered output, no bypass.
  - Latency: req fire in cycle N gives net_out_val in N+1.
  - Full throughput of one message per cycle when net_out_rdy is held high.
  - Msg = {req_dest, p_router_id, t, req_payload}.
  - net_out_msg is held stable while net_out_val && !net_out_rdy.
- Ejection path: 1-entry pipe register.
  - net_in_rdy = !resp_val || resp_rdy.
  - On net_in fire:
    - dest != p_router_id: drop, set err_misroute, no tag change.
    - Else if opaque < p_num_tags and busy[opaque]: clear busy, load response register.
    - Else: load response register, set err_spurious, no tag change.
  - Latency: 1 cycle from net_in fire to resp_val.
- outstanding = popcount(busy). A simultaneous alloc and free in one cycle leaves it unchanged.
- Self-send (req_dest == p_router_id) is legal. The router loops the message back and it retires normally.
- Error flags clear only on reset.

Decomposition:
- Shared package: net message field width/offset constants (wrapping VC_NET_MSG macros), the tag index type, and the response struct {src, opaque, payload}.
- One sub-module: net_endpoint_tag_alloc (busy vector, lowest-free priority encoder, free port, popcount).
- The injection queue reuses the existing 2-entry normal queue library block.

Test Plan:
- Single request, p_router_id=2: req dest=4, payload=0xff -> next cycle net_out_msg {dest=4, src=2, opq=0x00, payload=0xff}; outstanding=1.
- Loopback: inject msg {dest=2, src=4, opq=0, payload=0xab} on net_in -> next cycle resp_val, resp_src=4, resp_opaque=0, resp_payload=0xab; outstanding returns to 0.
- Tag exhaustion: 4 back-to-back reqs, no arrivals -> opaques 0,1,2,3; req_rdy=0 on the 5th. Return opq=1 -> next req gets opq=1.
- Same-cycle free of tag 0 with alloc while tags 0-2 busy -> new req gets opq 3, not 0; outstanding stays 3.
- Backpressure: net_out_rdy=0 for 5 cycles with 3 reqs offered -> only 2 accepted, net_out_msg stable; release drains in order with 1 msg/cycle.
- Errors: arrival with dest=5 -> dropped, err_misroute=1, no resp. Arrival with opq=2 while tag 2 free -> resp delivered, err_spurious=1. Assert reset low mid-traffic -> all outputs return to reset values immediately.
